// File: rtl/sync_pkg.sv
// sync_pkg: record layout helpers and colour truncation shared by the sync pair path.
package sync_pkg;
  localparam int MAXW = 32;
  typedef logic [MAXW-1:0] word_t;
  function automatic int rec_w(int cw, int iw);
    return 2*cw + 3*iw;
  endfunction
  function automatic int pend_w(int cw, int rw, int gw, int bw);
    return 2*cw + rw + gw + bw;
  endfunction
  function automatic int x_lsb(int cw, int iw);
    return cw + 3*iw;
  endfunction
  function automatic int y_lsb(int iw);
    return 3*iw;
  endfunction
  // Keeps the ow most significant bits of an iw-bit channel.
  function automatic word_t msb_trunc(word_t v, int iw, int ow);
    return v >> (iw - ow);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic show-ahead synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_25,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    full = count == NW'(DEPTH);
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    dout = mem[rp];
  end
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + NW'(do_push) - NW'(do_pop);
    end
  end
  always_ff @(posedge clk_25) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/sync_pair_controller.sv
// sync_pair_controller: issues FIFO pixels as homography queries and pairs each return
// with its pending DVI record, flagging coordinate mismatches and orphan returns.
module sync_pair_controller
  import sync_pkg::*;
#(
  parameter int CW = 10,
  parameter int IW = 8,
  parameter int RW = 5,
  parameter int GW = 6,
  parameter int BW = 5,
  parameter int DEPTH = 8,
  parameter int CHK_EN = 1
) (
  input  logic                    clk_25,
  input  logic                    rst_n,
  input  logic [2*CW+3*IW-1:0]    fifo_q,
  input  logic                    fifo_rdempty,
  output logic                    fifo_rdreq,
  output logic [CW-1:0]           query_x,
  output logic [CW-1:0]           query_y,
  output logic                    start,
  input  logic [CW-1:0]           return_x,
  input  logic [CW-1:0]           return_y,
  input  logic [RW-1:0]           r,
  input  logic [GW-1:0]           g,
  input  logic [BW-1:0]           b,
  input  logic                    ready,
  output logic                    val,
  output logic [CW-1:0]           sync_x,
  output logic [CW-1:0]           sync_y,
  output logic [RW-1:0]           dvi_r,
  output logic [GW-1:0]           dvi_g,
  output logic [BW-1:0]           dvi_b,
  output logic [RW-1:0]           ccd_r,
  output logic [GW-1:0]           ccd_g,
  output logic [BW-1:0]           ccd_b,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_mismatch,
  output logic                    err_orphan,
  input  logic                    err_clr
);
  localparam int PW = pend_w(CW, RW, GW, BW);
  localparam int NW = $clog2(DEPTH) + 1;
  logic rd_q, pop, mis, full, empty;
  logic [NW-1:0] count;
  logic [PW-1:0] din, head;
  logic [CW-1:0] fx, fy, hx, hy;
  logic [RW-1:0] fr, hr;
  logic [GW-1:0] fg, hg;
  logic [BW-1:0] fb, hb;
  always_comb begin
    fx = fifo_q[x_lsb(CW, IW) +: CW];
    fy = fifo_q[y_lsb(IW) +: CW];
    fr = RW'(msb_trunc(MAXW'(fifo_q[2*IW +: IW]), IW, RW));
    fg = GW'(msb_trunc(MAXW'(fifo_q[IW +: IW]), IW, GW));
    fb = BW'(msb_trunc(MAXW'(fifo_q[0 +: IW]), IW, BW));
    din = {fx, fy, fr, fg, fb};
    {hx, hy, hr, hg, hb} = head;
    pop = ready && !empty;
    mis = CHK_EN != 0 && (hx != return_x || hy != return_y);
    fifo_rdreq = rst_n && !fifo_rdempty && outstanding < NW'(DEPTH);
  end
  sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_pend (
    .clk_25, .rst_n, .push(rd_q), .pop, .din, .dout(head), .full, .empty, .count
  );
  // Credits count reads in flight as well as pending entries, so the queue cannot overflow.
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
      start <= 1'b0;
      query_x <= '0;
      query_y <= '0;
      val <= 1'b0;
      sync_x <= '0;
      sync_y <= '0;
      dvi_r <= '0;
      dvi_g <= '0;
      dvi_b <= '0;
      ccd_r <= '0;
      ccd_g <= '0;
      ccd_b <= '0;
      outstanding <= '0;
      err_mismatch <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      rd_q <= fifo_rdreq;
      start <= rd_q;
      if (rd_q) {query_x, query_y} <= {fx, fy};
      val <= pop;
      if (pop) {sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b} <= {head, r, g, b};
      outstanding <= outstanding + NW'(fifo_rdreq) - NW'(pop);
      err_mismatch <= (err_mismatch && !err_clr) || (pop && mis);
      err_orphan <= (err_orphan && !err_clr) || (ready && empty);
    end
  end
  assert property (@(posedge clk_25) disable iff (!rst_n) !(rd_q && full));
  assert property (@(posedge clk_25) disable iff (!rst_n) outstanding == count + NW'(rd_q));
endmodule

// File: tb/tb_sync_pair_controller.sv
// tb_sync_pair_controller: reactive FIFO/homography environment with a queue-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sync_pair_controller;
  localparam int CW = 10, IW = 8, RW = 5, GW = 6, BW = 5, DEPTH = 8;
  typedef struct { logic [CW-1:0] x, y; logic [IW-1:0] r, g, b; } rec_t;
  typedef struct { int due; logic [CW-1:0] x, y; logic [RW-1:0] r; logic [GW-1:0] g; logic [BW-1:0] b; } ret_t;
  logic clk_25 = 0, rst_n = 0, err_clr = 0;
  logic [2*CW+3*IW-1:0] fifo_q = '0;
  logic fifo_rdempty = 1, ready = 0;
  logic [CW-1:0] return_x = '0, return_y = '0;
  logic [RW-1:0] r = '0;
  logic [GW-1:0] g = '0;
  logic [BW-1:0] b = '0;
  logic fifo_rdreq, start, val, err_mismatch, err_orphan;
  logic [CW-1:0] query_x, query_y, sync_x, sync_y;
  logic [RW-1:0] dvi_r, ccd_r;
  logic [GW-1:0] dvi_g, ccd_g;
  logic [BW-1:0] dvi_b, ccd_b;
  logic [3:0] outstanding;
  logic u_fifo_rdreq, u_start, u_val, u_err_mismatch, u_err_orphan;
  logic [CW-1:0] u_query_x, u_query_y, u_sync_x, u_sync_y;
  logic [RW-1:0] u_dvi_r, u_ccd_r;
  logic [GW-1:0] u_dvi_g, u_ccd_g;
  logic [BW-1:0] u_dvi_b, u_ccd_b;
  logic [3:0] u_outstanding;

  sync_pair_controller dut (
    .clk_25(clk_25), .rst_n(rst_n), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq),
    .query_x(query_x), .query_y(query_y), .start(start), .return_x(return_x), .return_y(return_y),
    .r(r), .g(g), .b(b), .ready(ready), .val(val), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b), .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .outstanding(outstanding), .err_mismatch(err_mismatch), .err_orphan(err_orphan), .err_clr(err_clr)
  );
  sync_pair_controller #(.CHK_EN(0)) dut_nochk (
    .clk_25(clk_25), .rst_n(rst_n), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdreq(u_fifo_rdreq),
    .query_x(u_query_x), .query_y(u_query_y), .start(u_start), .return_x(return_x), .return_y(return_y),
    .r(r), .g(g), .b(b), .ready(ready), .val(u_val), .sync_x(u_sync_x), .sync_y(u_sync_y),
    .dvi_r(u_dvi_r), .dvi_g(u_dvi_g), .dvi_b(u_dvi_b), .ccd_r(u_ccd_r), .ccd_g(u_ccd_g), .ccd_b(u_ccd_b),
    .outstanding(u_outstanding), .err_mismatch(u_err_mismatch), .err_orphan(u_err_orphan), .err_clr(err_clr)
  );

  always #20 clk_25 = ~clk_25;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  rec_t recs [64];
  int src_wr = 0, inj_cnt = 0, delay = 3;
  logic corrupt = 0;

  rec_t pend [$];
  ret_t retq [$];
  rec_t rec_fly;
  logic rd_fly = 0;
  int src_rd = 0, inj_done = 0, cyc = 0, e_out = 0;
  logic e_val = 0, e_start = 0, e_mis = 0, e_orph = 0;
  logic [CW-1:0] e_qx = '0, e_qy = '0, e_sx = '0, e_sy = '0;
  logic [RW-1:0] e_dr = '0, e_cr = '0;
  logic [GW-1:0] e_dg = '0, e_cg = '0;
  logic [BW-1:0] e_db = '0, e_cb = '0;

  // Environment and model: compare what the last edge produced, drive the next edge, predict it.
  initial forever begin
    ret_t t;
    rec_t h;
    logic rq, pop_e;
    @(negedge clk_25);
    if (cyc > 0) begin
      chk("val", 64'(val), 64'(e_val));
      chk("start", 64'(start), 64'(e_start));
      chk("query", 64'({query_x, query_y}), 64'({e_qx, e_qy}));
      chk("pair", 64'({sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}),
          64'({e_sx, e_sy, e_dr, e_dg, e_db, e_cr, e_cg, e_cb}));
      chk("outstanding", 64'(outstanding), 64'(e_out));
      chk("err_mismatch", 64'(err_mismatch), 64'(e_mis));
      chk("err_orphan", 64'(err_orphan), 64'(e_orph));
      chk("nochk err_mismatch", 64'(u_err_mismatch), 64'(0));
      chk("nochk pair", 64'({u_val, u_sync_x, u_sync_y, u_dvi_r, u_ccd_b, u_outstanding, u_err_orphan}),
          64'({e_val, e_sx, e_sy, e_dr, e_cb, 4'(e_out), e_orph}));
    end
    fifo_rdempty = src_rd == src_wr;
    if (rd_fly) fifo_q = {rec_fly.x, rec_fly.y, rec_fly.r, rec_fly.g, rec_fly.b};
    ready = 0;
    if (inj_done < inj_cnt) begin
      inj_done++;
      ready = 1;
      return_x = 10'h3AA;
      return_y = 10'h155;
    end else if (retq.size() > 0 && retq[0].due <= cyc) begin
      t = retq.pop_front();
      ready = 1;
      return_x = t.x;
      return_y = t.y;
      r = t.r;
      g = t.g;
      b = t.b;
    end
    #1;
    rq = rst_n && (src_rd != src_wr) && (pend.size() + int'(rd_fly) < DEPTH);
    if (cyc > 0) chk("fifo_rdreq", 64'(fifo_rdreq), 64'(rq));
    if (!rst_n) begin
      pend.delete();
      rd_fly = 0;
      {e_val, e_start, e_mis, e_orph, e_qx, e_qy, e_sx, e_sy} = '0;
      {e_dr, e_dg, e_db, e_cr, e_cg, e_cb} = '0;
      e_out = 0;
    end else begin
      pop_e = ready && pend.size() > 0;
      e_orph = (e_orph && !err_clr) || (ready && pend.size() == 0);
      e_mis = e_mis && !err_clr;
      e_val = pop_e;
      if (pop_e) begin
        h = pend.pop_front();
        e_sx = h.x;
        e_sy = h.y;
        e_dr = RW'(h.r >> (IW - RW));
        e_dg = GW'(h.g >> (IW - GW));
        e_db = BW'(h.b >> (IW - BW));
        e_cr = r;
        e_cg = g;
        e_cb = b;
        if (h.x != return_x || h.y != return_y) e_mis = 1;
      end
      e_start = rd_fly;
      if (rd_fly) begin
        pend.push_back(rec_fly);
        e_qx = rec_fly.x;
        e_qy = rec_fly.y;
        t.due = cyc + 1 + delay;
        t.x = rec_fly.x + CW'(corrupt);
        t.y = rec_fly.y;
        t.r = RW'($urandom);
        t.g = GW'($urandom);
        t.b = BW'($urandom);
        retq.push_back(t);
      end
      rd_fly = rq;
      if (rq) begin
        rec_fly = recs[src_rd];
        src_rd++;
      end
      e_out = pend.size() + int'(rd_fly);
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_25);
    #2;
  endtask
  task automatic push_rec(input int x, input int y, input int rr, input int gg, input int bb);
    recs[src_wr].x = CW'(x);
    recs[src_wr].y = CW'(y);
    recs[src_wr].r = IW'(rr);
    recs[src_wr].g = IW'(gg);
    recs[src_wr].b = IW'(bb);
    src_wr++;
  endtask
  task automatic count_vals(input int want, input int lim, output int got);
    got = 0;
    for (int i = 0; i < lim && got < want; i++) begin
      step(1);
      got += int'(val);
    end
  endtask
  task automatic clear_flags();
    err_clr = 1;
    step(1);
    err_clr = 0;
  endtask

  initial begin
    int got, run, max_run;
    bit seen;
    step(2);
    rst_n = 1;
    step(1);
    chk("reset outstanding", 64'(outstanding), 64'(0));
    chk("reset flags", 64'({val, start, err_mismatch, err_orphan}), 64'(0));

    push_rec(100, 50, 'hFF, 'h80, 'h01);
    count_vals(1, 30, got);
    chk("single val seen", 64'(got), 64'(1));
    chk("single sync", 64'({sync_x, sync_y}), 64'({10'd100, 10'd50}));
    chk("single dvi", 64'({dvi_r, dvi_g, dvi_b}), 64'({5'd31, 6'd32, 5'd0}));
    chk("single flags", 64'({err_mismatch, err_orphan}), 64'(0));
    step(1);
    chk("single val one cycle", 64'(val), 64'(0));

    delay = 6;
    for (int i = 0; i < 20; i++) push_rec(i * 7, 500 - i, i * 13, 255 - i, i);
    got = 0;
    seen = 0;
    for (int i = 0; i < 400 && got < 20; i++) begin
      step(1);
      got += int'(val);
      if (outstanding == 4'd8 && !fifo_rdreq && !fifo_rdempty) seen = 1;
    end
    chk("burst pairs", 64'(got), 64'(20));
    chk("burst credit stall", 64'(seen), 64'(1));
    step(4);

    delay = 3;
    corrupt = 1;
    push_rec(100, 50, 'h10, 'h20, 'h30);
    count_vals(1, 30, got);
    corrupt = 0;
    chk("mismatch val", 64'(got), 64'(1));
    chk("mismatch sync_x", 64'(sync_x), 64'(100));
    chk("mismatch flag", 64'(err_mismatch), 64'(1));
    chk("mismatch nochk flag", 64'(u_err_mismatch), 64'(0));
    step(2);
    chk("mismatch held", 64'(err_mismatch), 64'(1));
    clear_flags();
    chk("mismatch cleared", 64'(err_mismatch), 64'(0));

    step(4);
    inj_cnt++;
    step(1);
    chk("orphan no val", 64'(val), 64'(0));
    chk("orphan flag", 64'(err_orphan), 64'(1));
    clear_flags();
    chk("orphan cleared", 64'(err_orphan), 64'(0));

    delay = 2;
    for (int i = 0; i < 12; i++) push_rec(300 + i, 200 + 2 * i, 'hA0 + i, 'h5 * i, 'hF0 - i);
    got = 0;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 100 && got < 12; i++) begin
      step(1);
      got += int'(val);
      run = (outstanding == 4'd4 && val) ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("steady pairs", 64'(got), 64'(12));
    chk("steady occupancy 4", 64'(max_run >= 4), 64'(1));
    step(4);

    delay = 10;
    for (int i = 0; i < 5; i++) push_rec(40 + i, 30 + i, 'h11, 'h22, 'h33);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      seen = outstanding == 4'd5;
    end
    chk("preload 5 outstanding", 64'(seen), 64'(1));
    rst_n = 0;
    step(1);
    rst_n = 1;
    chk("midreset outstanding", 64'(outstanding), 64'(0));
    chk("midreset outputs", 64'({val, start, fifo_rdreq, err_mismatch, err_orphan, query_x, sync_x, dvi_r, ccd_r}), 64'(0));
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1);
      seen = err_orphan;
    end
    chk("post-reset orphan", 64'(seen), 64'(1));
    step(20);
    clear_flags();
    delay = 3;
    for (int i = 0; i < 3; i++) push_rec(600 + i, 700 + i, 'hC0, 'h40, 'h08);
    count_vals(3, 60, got);
    chk("resume pairs", 64'(got), 64'(3));
    chk("resume flags", 64'({err_mismatch, err_orphan}), 64'(0));
    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
